ram64_arbiter: RTL and testbench

Shares one RAM64 instance between two requesters, A and B, using a valid/ready handshake and round-robin arbitration. It grants at most one access per cycle. It also provides a hardware clear sequencer that fills all 64 words with a constant while both requesters are stalled. It sits between the RAM64 and its two clients (for example CPU data port and a DMA/debug port), and it owns the RAM64 clk/load/address/in pins exclusively.

---
 rtl/ram64_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ram64_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram64_arbiter.sv
// Round-robin arbiter sharing one RAM64 between requesters A and B, with a
// hardware clear sequencer that fills every word with CLR_VALUE.
module ram64_arbiter #(
    parameter int                ADDR_W    = 6,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] CLR_VALUE = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_valid,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_valid,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,

    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    typedef enum logic {
        SIDE_A,
        SIDE_B
    } side_t;

    state_t            state_q,     state_d;
    side_t             rr_ptr_q,    rr_ptr_d;
    logic [ADDR_W-1:0] clr_cnt_q,   clr_cnt_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              a_rvalid_q,  a_rvalid_d;
    logic              b_rvalid_q,  b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q,   a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q,   b_rdata_d;
    logic              clr_done_q,  clr_done_d;

    logic              grant_a;
    logic              grant_b;
    logic              load_c;
    logic [ADDR_W-1:0] address_c;
    logic [DATA_W-1:0] in_c;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        clr_cnt_d   = clr_cnt_q;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        clr_done_d  = 1'b0;
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        load_c      = 1'b0;
        address_c   = last_addr_q;
        in_c        = CLR_VALUE;

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                end else begin
                    // On contention the side named by rr_ptr wins.
                    grant_a = a_valid & (~b_valid | (rr_ptr_q == SIDE_A));
                    grant_b = b_valid & (~a_valid | (rr_ptr_q == SIDE_B));
                end

                if (grant_a) begin
                    address_c  = a_addr;
                    in_c       = a_wdata;
                    load_c     = a_we;
                    rr_ptr_d   = SIDE_B;
                    a_rvalid_d = ~a_we;
                    if (!a_we) begin
                        a_rdata_d = ram_out;
                    end
                end else if (grant_b) begin
                    address_c  = b_addr;
                    in_c       = b_wdata;
                    load_c     = b_we;
                    rr_ptr_d   = SIDE_A;
                    b_rvalid_d = ~b_we;
                    if (!b_we) begin
                        b_rdata_d = ram_out;
                    end
                end
            end

            CLEAR: begin
                load_c    = 1'b1;
                address_c = clr_cnt_q;
                in_c      = CLR_VALUE;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        last_addr_d = address_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= SIDE_A;
            clr_cnt_q   <= '0;
            last_addr_q <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            clr_cnt_q   <= clr_cnt_d;
            last_addr_q <= last_addr_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            clr_done_q  <= clr_done_d;
        end
    end

    // Handshake and write strobe are forced low while reset is held.
    assign a_ready     = grant_a & rst_n;
    assign b_ready     = grant_b & rst_n;
    assign ram_load    = load_c & rst_n;
    assign ram_address = address_c;
    assign ram_in      = in_c;

    assign a_rvalid    = a_rvalid_q;
    assign b_rvalid    = b_rvalid_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign clr_busy    = (state_q == CLEAR);
    assign clr_done    = clr_done_q;

endmodule

// File: tb/tb_ram64_arbiter.sv
// Self-checking bench for ram64_arbiter: behavioural RAM64, a transaction-level
// reference model checked every cycle, and directed scenarios with literal results.
module tb_ram64_arbiter;

    localparam logic [15:0] CLR_VALUE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid, a_we, b_valid, b_we, clr_start;
    logic [5:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ready, a_rvalid, b_ready, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic        clr_busy, clr_done, ram_load;
    logic [5:0]  ram_address;
    logic [15:0] ram_in, ram_out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    ram64_arbiter #(.ADDR_W(6), .DATA_W(16), .CLR_VALUE(CLR_VALUE)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in),
        .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    // RAM64 stand-in: synchronous write, combinational read, no reset.
    logic [15:0] ram_mem [64] = '{default: 16'hA5A5};
    always @(posedge clk) begin
        if (ram_load) ram_mem[ram_address] <= ram_in;
    end
    assign ram_out = ram_mem[ram_address];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: expected memory image, remaining clear words,
    // who was served last, and pending read responses.
    logic [15:0] m_mem [64] = '{default: 16'hA5A5};
    int          m_clear_rem;
    logic        m_last_b;
    logic        m_done;
    logic        m_a_rv, m_b_rv;
    logic [15:0] m_a_rd, m_b_rd;
    logic [5:0]  m_last_addr;
    logic        m_addr_known;

    function automatic logic exp_grant_a();
        if (m_clear_rem != 0 || clr_start) return 1'b0;
        if (a_valid && b_valid) return m_last_b;
        return a_valid;
    endfunction

    function automatic logic exp_grant_b();
        if (m_clear_rem != 0 || clr_start) return 1'b0;
        if (a_valid && b_valid) return !m_last_b;
        return b_valid;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear_rem  <= 0;
            m_last_b     <= 1'b1;
            m_done       <= 1'b0;
            m_a_rv       <= 1'b0;
            m_b_rv       <= 1'b0;
            m_a_rd       <= '0;
            m_b_rd       <= '0;
            m_addr_known <= 1'b0;
            m_last_addr  <= '0;
        end else begin
            m_done <= (m_clear_rem == 1);
            m_a_rv <= exp_grant_a() && !a_we;
            m_b_rv <= exp_grant_b() && !b_we;
            if (m_clear_rem != 0) begin
                m_mem[64 - m_clear_rem] <= CLR_VALUE;
                m_last_addr  <= 6'(64 - m_clear_rem);
                m_addr_known <= 1'b1;
                m_clear_rem  <= m_clear_rem - 1;
            end else if (clr_start) begin
                m_clear_rem <= 64;
            end
            if (exp_grant_a()) begin
                if (a_we) m_mem[a_addr] <= a_wdata;
                else      m_a_rd <= m_mem[a_addr];
                m_last_b     <= 1'b0;
                m_last_addr  <= a_addr;
                m_addr_known <= 1'b1;
            end
            if (exp_grant_b()) begin
                if (b_we) m_mem[b_addr] <= b_wdata;
                else      m_b_rd <= m_mem[b_addr];
                m_last_b     <= 1'b1;
                m_last_addr  <= b_addr;
                m_addr_known <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst a_ready", a_ready, 0);
            checkOutput("rst b_ready", b_ready, 0);
            checkOutput("rst ram_load", ram_load, 0);
            checkOutput("rst a_rvalid", a_rvalid, 0);
            checkOutput("rst b_rvalid", b_rvalid, 0);
            checkOutput("rst a_rdata", a_rdata, 0);
            checkOutput("rst b_rdata", b_rdata, 0);
            checkOutput("rst clr_busy", clr_busy, 0);
            checkOutput("rst clr_done", clr_done, 0);
        end else begin
            checkOutput("a_ready", a_ready, exp_grant_a());
            checkOutput("b_ready", b_ready, exp_grant_b());
            checkOutput("ram_load", ram_load,
                        (m_clear_rem != 0) || (exp_grant_a() && a_we) || (exp_grant_b() && b_we));
            if (m_clear_rem != 0) begin
                checkOutput("clear ram_address", ram_address, 64 - m_clear_rem);
                checkOutput("clear ram_in", ram_in, CLR_VALUE);
            end else if (exp_grant_a()) begin
                checkOutput("A ram_address", ram_address, a_addr);
                if (a_we) checkOutput("A ram_in", ram_in, a_wdata);
            end else if (exp_grant_b()) begin
                checkOutput("B ram_address", ram_address, b_addr);
                if (b_we) checkOutput("B ram_in", ram_in, b_wdata);
            end else if (m_addr_known) begin
                checkOutput("held ram_address", ram_address, m_last_addr);
            end
            checkOutput("a_rvalid", a_rvalid, m_a_rv);
            checkOutput("b_rvalid", b_rvalid, m_b_rv);
            checkOutput("a_rdata", a_rdata, m_a_rd);
            checkOutput("b_rdata", b_rdata, m_b_rd);
            checkOutput("clr_busy", clr_busy, m_clear_rem != 0);
            checkOutput("clr_done", clr_done, m_done);
        end
    end

    logic        s_a_ready, s_b_ready, s_a_rvalid, s_b_rvalid, s_clr_busy, s_clr_done;
    logic [15:0] s_a_rdata, s_b_rdata;

    task automatic applyStimulus(input logic av, input logic awe, input logic [5:0] aad,
                                 input logic [15:0] awd, input logic bv, input logic bwe,
                                 input logic [5:0] bad, input logic [15:0] bwd,
                                 input logic clr);
        a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
        b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
        clr_start = clr;
        @(negedge clk);
        s_a_ready  = a_ready;  s_b_ready  = b_ready;
        s_a_rvalid = a_rvalid; s_b_rvalid = b_rvalid;
        s_a_rdata  = a_rdata;  s_b_rdata  = b_rdata;
        s_clr_busy = clr_busy; s_clr_done = clr_done;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic writeA(input logic [5:0] addr, input logic [15:0] data);
        applyStimulus(1, 1, addr, data, 0, 0, 0, 0, 0);
        checkOutput("writeA ready", s_a_ready, 1);
    endtask

    task automatic readA(input logic [5:0] addr, input logic [15:0] exp, input string name);
        applyStimulus(1, 0, addr, 0, 0, 0, 0, 0, 0);
        checkOutput({name, " ready"}, s_a_ready, 1);
        idleCycle();
        checkOutput({name, " rvalid"}, s_a_rvalid, 1);
        checkOutput(name, s_a_rdata, exp);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] gseq;
        int         a_cnt, b_cnt, busy_cnt, done_cnt, first;

        a_valid = 1; a_we = 0; a_addr = 0; a_wdata = 0;
        b_valid = 1; b_we = 0; b_addr = 0; b_wdata = 0;
        clr_start = 0;
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back on consecutive cycles.
        writeA(6'd5, 16'hBEEF);
        readA(6'd5, 16'hBEEF, "A read BEEF");

        // Both requesters contending alternate, starting with A after reset.
        doReset();
        gseq = '0; a_cnt = 0; b_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 6'd1, 0, 1, 0, 6'd2, 0, 0);
            gseq = {gseq[4:0], s_a_ready};
            a_cnt += int'(s_a_rvalid);
            b_cnt += int'(s_b_rvalid);
        end
        idleCycle();
        a_cnt += int'(s_a_rvalid);
        b_cnt += int'(s_b_rvalid);
        checkOutput("grant sequence", gseq, 6'b101010);
        checkOutput("A rvalid pulses", a_cnt, 3);
        checkOutput("B rvalid pulses", b_cnt, 3);

        // B alone three times, then contention goes to A.
        b_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 6'd2, 0, 0);
            b_cnt += int'(s_b_ready);
        end
        checkOutput("B solo grants", b_cnt, 3);
        applyStimulus(1, 0, 6'd1, 0, 1, 0, 6'd2, 0, 0);
        checkOutput("contention A ready", s_a_ready, 1);
        checkOutput("contention B ready", s_b_ready, 0);
        idleCycle();

        // Full clear with a stray clr_start mid-sequence.
        writeA(6'd0, 16'h1234);
        writeA(6'd31, 16'h1234);
        writeA(6'd63, 16'h1234);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        busy_cnt = 0; done_cnt = 0;
        for (int i = 1; i <= 66; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, i == 10);
            busy_cnt += int'(s_clr_busy);
            done_cnt += int'(s_clr_done);
        end
        checkOutput("clear busy cycles", busy_cnt, 64);
        checkOutput("clear done pulses", done_cnt, 1);
        readA(6'd0, 16'h0000, "cleared addr 0");
        readA(6'd31, 16'h0000, "cleared addr 31");
        readA(6'd63, 16'h0000, "cleared addr 63");

        // clr_start beats a simultaneous A read; A served once clear ends.
        applyStimulus(1, 0, 6'd5, 0, 0, 0, 0, 0, 1);
        checkOutput("clr_start A ready", s_a_ready, 0);
        first = -1;
        for (int i = 1; i <= 70; i++) begin
            applyStimulus(1, 0, 6'd5, 0, 0, 0, 0, 0, 0);
            if (s_a_ready) begin
                first = i;
                checkOutput("grant with clr_done", s_clr_done, 1);
                break;
            end
        end
        checkOutput("first A grant after clear", first, 65);
        idleCycle();
        checkOutput("post-clear A rvalid", s_a_rvalid, 1);
        checkOutput("post-clear A rdata", s_a_rdata, 16'h0000);

        // Reset during clear cycle 20 aborts without clr_done.
        writeA(6'd0, 16'h1111);
        writeA(6'd19, 16'h1919);
        writeA(6'd20, 16'h2020);
        writeA(6'd40, 16'h4040);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) idleCycle();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid-clear reset busy", clr_busy, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            busy_cnt += int'(s_clr_busy);
            done_cnt += int'(s_clr_done);
        end
        checkOutput("aborted clear busy", busy_cnt, 0);
        checkOutput("aborted clear done", done_cnt, 0);
        readA(6'd0, 16'h0000, "partial clear addr 0");
        readA(6'd19, 16'h0000, "partial clear addr 19");
        readA(6'd20, 16'h2020, "partial clear addr 20");
        readA(6'd40, 16'h4040, "partial clear addr 40");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
